vga_mono_dither: RTL and testbench

- Registered video output stage between the system core's 6-bit-per-channel RGB and the board's 3-bit-per-channel VGA DAC pins.
- Applies the monochrome tint selected by monochrome_switcher: color, green, amber or grey.
- Reduces each channel from 6 to 3 bits using 2x2 ordered dithering instead of plain truncation.
- Delays hsync/vsync so they stay aligned with the pixel pipeline.

---
 rtl/vga_mono_dither.sv | 173 +++++++++++++++++
 tb/tb_vga_mono_dither.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mono_dither.sv
// Video output stage: 6-bit RGB in, optional monochrome tint, 2x2 ordered
// dither down to 3 bits per channel, syncs delayed to match the 3-stage pipe.
module vga_mono_dither #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter bit DITHER_EN       = 1'b1
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] monochrome_switcher,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       hsync_out,
  output logic       vsync_out
);

  typedef enum logic [1:0] {
    MODE_COLOR = 2'b00,
    MODE_GREEN = 2'b01,
    MODE_AMBER = 2'b10,
    MODE_GREY  = 2'b11
  } mode_t;

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  // pix_ce is a qualifier, not a handshake: a pixel is accepted and every
  // stage advances on each clk_vga edge where pix_ce is high; otherwise all hold.

  mode_t      mode;
  logic [5:0] s1_r, s1_g, s1_b;
  logic       s1_hs, s1_vs;
  logic       x_par, y_par;
  logic       hs_prev, vs_prev;
  logic       hs_act, vs_act, hs_edge, vs_edge;

  logic [5:0] s2_r, s2_g, s2_b;
  logic       s2_hs, s2_vs, s2_x, s2_y;

  logic [13:0] luma_sum;
  logic [5:0]  luma;
  logic [5:0]  tint_r, tint_g, tint_b;
  logic [2:0]  thresh;

  // Sync levels normalised so that 1 always means "pulse active".
  assign hs_act  = hsync_in ^ SYNC_IDLE;
  assign vs_act  = vsync_in ^ SYNC_IDLE;
  assign hs_edge = hs_act & ~hs_prev;
  assign vs_edge = vs_act & ~vs_prev;

  function automatic logic [2:0] dither_ch(input logic [5:0] v, input logic [2:0] t);
    logic [6:0] sum;
    sum = {1'b0, v} + {4'b0000, t};
    return sum[6] ? 3'd7 : 3'(sum >> 3);
  endfunction

  // Stage 1: input capture, dither coordinates and frame-locked mode.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
      s1_hs   <= SYNC_IDLE;
      s1_vs   <= SYNC_IDLE;
      x_par   <= 1'b0;
      y_par   <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      mode    <= MODE_COLOR;
    end else if (pix_ce) begin
      s1_r    <= r_in;
      s1_g    <= g_in;
      s1_b    <= b_in;
      s1_hs   <= hsync_in;
      s1_vs   <= vsync_in;
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      x_par   <= hs_edge ? 1'b0 : ~x_par;
      if (vs_edge) begin
        y_par <= 1'b0;
        mode  <= mode_t'(monochrome_switcher);
      end else if (hs_edge) begin
        y_par <= ~y_par;
      end
    end
  end

  assign luma_sum = 14'd54  * {8'd0, s1_r}
                  + 14'd183 * {8'd0, s1_g}
                  + 14'd18  * {8'd0, s1_b};
  assign luma     = 6'(luma_sum >> 8);

  always_comb begin
    tint_r = s1_r;
    tint_g = s1_g;
    tint_b = s1_b;
    case (mode)
      MODE_GREEN: begin
        tint_r = '0;
        tint_g = luma;
        tint_b = '0;
      end
      MODE_AMBER: begin
        tint_r = luma;
        tint_g = luma >> 1;
        tint_b = '0;
      end
      MODE_GREY: begin
        tint_r = luma;
        tint_g = luma;
        tint_b = luma;
      end
      default: ;
    endcase
  end

  // Stage 2: tinted 6-bit channels, with syncs and coordinates carried along.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s2_r  <= '0;
      s2_g  <= '0;
      s2_b  <= '0;
      s2_hs <= SYNC_IDLE;
      s2_vs <= SYNC_IDLE;
      s2_x  <= 1'b0;
      s2_y  <= 1'b0;
    end else if (pix_ce) begin
      s2_r  <= tint_r;
      s2_g  <= tint_g;
      s2_b  <= tint_b;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_x  <= x_par;
      s2_y  <= y_par;
    end
  end

  // Bayer 2x2 thresholds, scaled to the 3 bits being dropped.
  always_comb begin
    thresh = 3'd0;
    if (DITHER_EN) begin
      case ({s2_y, s2_x})
        2'b01:   thresh = 3'd4;
        2'b10:   thresh = 3'd6;
        2'b11:   thresh = 3'd2;
        default: thresh = 3'd0;
      endcase
    end
  end

  // Stage 3: registered DAC outputs.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else if (pix_ce) begin
      vga_r     <= dither_ch(s2_r, thresh);
      vga_g     <= dither_ch(s2_g, thresh);
      vga_b     <= dither_ch(s2_b, thresh);
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
    end
  end

endmodule

// File: tb/tb_vga_mono_dither.sv
// Bench for vga_mono_dither: one dithering active-low-sync instance and one
// plain active-high-sync instance share stimulus and one scoreboard queue.
module tb_vga_mono_dither;

  localparam int W = 22;
  localparam logic [W-1:0] RST_VEC = {3'd0, 3'd0, 3'd0, 1'b1, 1'b1,
                                      3'd0, 3'd0, 3'd0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_ce = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_a = 1'b0, vs_a = 1'b0;
  logic       hsync_l, vsync_l;
  logic [1:0] sw = 2'b00;

  logic [2:0] r_d, g_d, b_d, r_n, g_n, b_n;
  logic       hs_d, vs_d, hs_n, vs_n;

  assign hsync_l = ~hs_a;
  assign vsync_l = ~vs_a;

  vga_mono_dither #(.SYNC_ACTIVE_LOW(1'b1), .DITHER_EN(1'b1)) dut_d (
    .clk_vga(clk), .rst(rst), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_l), .vsync_in(vsync_l), .monochrome_switcher(sw),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .hsync_out(hs_d), .vsync_out(vs_d)
  );

  vga_mono_dither #(.SYNC_ACTIVE_LOW(1'b0), .DITHER_EN(1'b0)) dut_n (
    .clk_vga(clk), .rst(rst), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hs_a), .vsync_in(vs_a), .monochrome_switcher(sw),
    .vga_r(r_n), .vga_g(g_n), .vga_b(b_n), .hsync_out(hs_n), .vsync_out(vs_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  int m_hs_prev, m_vs_prev, m_x, m_y, m_mode;
  int thr[4] = '{0, 4, 6, 2};  // indexed by y*2 + x

  function automatic int quant(input int v, input int t);
    int s;
    s = (v + t) / 8;
    return (s > 7) ? 7 : s;
  endfunction

  always @(posedge clk) begin
    int hs_e, vs_e, yl, cr, cg, cb, t;
    logic [10:0] ed, en;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RST_VEC);
      exp_q.push_back(RST_VEC);
      m_hs_prev = 0; m_vs_prev = 0; m_x = 0; m_y = 0; m_mode = 0;
    end else if (pix_ce) begin
      hs_e = (hs_a && m_hs_prev == 0) ? 1 : 0;
      vs_e = (vs_a && m_vs_prev == 0) ? 1 : 0;
      m_x = hs_e ? 0 : 1 - m_x;
      if (vs_e) m_y = 0;
      else if (hs_e) m_y = 1 - m_y;
      if (vs_e) m_mode = int'(sw);
      m_hs_prev = int'(hs_a);
      m_vs_prev = int'(vs_a);
      yl = (54 * int'(r_in) + 183 * int'(g_in) + 18 * int'(b_in)) / 256;
      case (m_mode)
        1: begin cr = 0;  cg = yl;     cb = 0;  end
        2: begin cr = yl; cg = yl / 2; cb = 0;  end
        3: begin cr = yl; cg = yl;     cb = yl; end
        default: begin cr = int'(r_in); cg = int'(g_in); cb = int'(b_in); end
      endcase
      t = thr[m_y * 2 + m_x];
      ed = {3'(quant(cr, t)), 3'(quant(cg, t)), 3'(quant(cb, t)), ~hs_a, ~vs_a};
      en = {3'(quant(cr, 0)), 3'(quant(cg, 0)), 3'(quant(cb, 0)), hs_a, vs_a};
      exp_q.push_back({ed, en});
    end
  end

  // ---------------- monitor ----------------
  logic armed = 1'b0;
  logic [W-1:0] last_v = RST_VEC;

  always @(posedge clk) begin
    logic c, rr;
    logic [W-1:0] got, exp_v;
    c = pix_ce;
    rr = rst;
    #1;
    got = {r_d, g_d, b_d, hs_d, vs_d, r_n, g_n, b_n, hs_n, vs_n};
    if (rr) begin
      armed = 1'b1;
      check("reset", got, RST_VEC);
      last_v = RST_VEC;
    end else if (armed && c) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow t=%0t got=%h expected=queued entry", $time, got);
      end else begin
        exp_v = exp_q.pop_front();
        check("pixel", got, exp_v);
        last_v = exp_v;
      end
    end else if (armed) begin
      check("hold", got, last_v);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic ce, input logic [5:0] r, input logic [5:0] g,
                     input logic [5:0] b, input logic hs, input logic vs,
                     input logic [1:0] s);
    @(posedge clk);
    #3;
    rst = 1'b0;
    pix_ce = ce;
    r_in = r; g_in = g; b_in = b;
    hs_a = hs; vs_a = vs;
    sw = s;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) cyc(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, s);
  endtask

  task automatic vsync_pulse(input logic [1:0] s);
    cyc(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, s);
    cyc(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, s);
    cyc(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, s);
  endtask

  task automatic line_of(input logic [5:0] rv, input int n, input logic [1:0] s);
    for (int c = 0; c < n; c++) cyc(1'b1, rv, 6'd0, 6'd0, (c < 2), 1'b0, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int col, row;
    logic ce;
    logic [1:0] rs;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // colour passthrough with an hsync pulse riding along
    cyc(1'b1, 6'd63, 6'd32, 6'd7, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00);
    idle(4, 2'b00);

    // grey, green, amber; each selected on a vsync assert edge
    vsync_pulse(2'b11);
    cyc(1'b1, 6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 2'b11);
    cyc(1'b1, 6'd0, 6'd63, 6'd0, 1'b0, 1'b0, 2'b11);
    vsync_pulse(2'b01);
    cyc(1'b1, 6'd0, 6'd63, 6'd0, 1'b0, 1'b0, 2'b01);
    vsync_pulse(2'b10);
    cyc(1'b1, 6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 2'b10);
    vsync_pulse(2'b00);

    // dither pattern over two lines, saturation, frame restart
    line_of(6'd4, 8, 2'b00);
    line_of(6'd4, 8, 2'b00);
    line_of(6'd63, 6, 2'b00);
    vsync_pulse(2'b00);
    line_of(6'd4, 6, 2'b00);

    // switcher moves mid-line; tint must wait for the next vsync edge
    line_of(6'd40, 4, 2'b00);
    line_of(6'd40, 4, 2'b11);
    vsync_pulse(2'b11);
    cyc(1'b1, 6'd63, 6'd10, 6'd20, 1'b0, 1'b0, 2'b11);
    vsync_pulse(2'b00);

    // alternating pix_ce
    for (int i = 0; i < 24; i++)
      cyc(1'(i % 2), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          6'($urandom_range(0, 63)), (i % 12) < 4, 1'b0, 2'b00);

    // reset pulsed mid-line, then a fresh line
    line_of(6'd4, 5, 2'b00);
    do_reset(1);
    line_of(6'd4, 8, 2'b00);

    // random frames with random ce, tint changes and rare resets
    col = 0;
    row = 0;
    rs = 2'b00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
        col = 0;
        row = 0;
      end
      if ($urandom_range(0, 49) == 0) rs = 2'($urandom_range(0, 3));
      ce = ($urandom_range(0, 3) != 0);
      cyc(ce, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          6'($urandom_range(0, 63)), (col < 2), (row == 0 && col < 6), rs);
      if (ce) begin
        col++;
        if (col == 12) begin
          col = 0;
          row = (row + 1) % 4;
        end
      end
    end

    idle(5, 2'b00);
    @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL drain queue_size=%0d expected=2", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
